// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the receive packet packer: FSM encoding,
// default sizing and the saturating length helper.
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_RECEIVE  = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_COMPLETE = 3'd4
  } state_t;

  localparam int              FIFO_DEPTH_DEF = 8;
  localparam int              LEN_W          = 11;
  localparam int              WORD_W         = 16;
  localparam logic [LEN_W-1:0] MAX_LEN_DEF   = 11'd1518;

  // Frame byte count sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] len);
    return (len == {LEN_W{1'b1}}) ? len : len + 11'd1;
  endfunction

endpackage

// File: rtl/rx_packet_packer_if.sv
// MAC byte stream, consumer handshake and packed-word outputs of the packer.
interface rx_packet_packer_if;
  import rx_pkt_pkg::*;

  logic [7:0]        mac_rx_data_in;
  logic              mac_rx_valid_in;
  logic              mac_rx_sof_in;
  logic              mac_rx_eof_in;
  logic              rx_req_in;
  logic              test_pop_block;
  logic [WORD_W-1:0] rx_packet_data_out;
  logic              rx_packet_data_rdy_out;
  logic              rx_packet_complete_out;
  logic [LEN_W-1:0]  rx_packet_length_out;
  logic              rx_overflow_out;

  // Source side: MAC model plus consumer request.
  modport master (
    output mac_rx_data_in, mac_rx_valid_in, mac_rx_sof_in, mac_rx_eof_in,
    output rx_req_in, test_pop_block,
    input  rx_packet_data_out, rx_packet_data_rdy_out, rx_packet_complete_out,
    input  rx_packet_length_out, rx_overflow_out
  );

  // Packer side.
  modport slave (
    input  mac_rx_data_in, mac_rx_valid_in, mac_rx_sof_in, mac_rx_eof_in,
    input  rx_req_in, test_pop_block,
    output rx_packet_data_out, rx_packet_data_rdy_out, rx_packet_complete_out,
    output rx_packet_length_out, rx_overflow_out
  );

endinterface

// File: rtl/rx_word_fifo.sv
// Synchronous 16-bit word FIFO with full/empty flags and a flush that
// empties it in one cycle. Push while full is accepted only with a pop.
module rx_word_fifo
  import rx_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/rx_packet_packer.sv
// Packs a MAC byte stream into big-endian 16-bit words for a consumer
// that requests one packet at a time, reporting length and overflow.
module rx_packet_packer
  import rx_pkt_pkg::*;
#(
  parameter int               FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [LEN_W-1:0] MAX_LEN    = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  rx_packet_packer_if.slave  bus
);

  state_t            state;
  logic [7:0]        hi_byte_p0;
  logic              odd_p0;
  logic              push_vld_p0;
  logic [WORD_W-1:0] push_word_p0;
  logic [LEN_W-1:0]  length;
  logic [LEN_W-1:0]  len_nxt;
  logic              overflow;
  logic              complete;
  logic [WORD_W-1:0] data_p1;
  logic              vld_p1;

  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              abort;
  logic              pop;
  logic              drop;

  // Consumer withdrawing its request while a packet is in flight abandons it.
  assign abort   = (state == ST_WAIT_SOF || state == ST_RECEIVE || state == ST_DRAIN)
                   && !bus.rx_req_in;
  assign pop     = !fifo_empty && (state == ST_RECEIVE || state == ST_DRAIN)
                   && bus.rx_req_in && !bus.test_pop_block;
  assign drop    = push_vld_p0 && fifo_full && !pop && !abort;
  assign len_nxt = len_sat_inc(length);

  rx_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push_vld_p0),
    .wdata (push_word_p0),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Packet FSM: byte pairing, length/overflow tracking, completion strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hi_byte_p0   <= '0;
      odd_p0       <= 1'b0;
      push_vld_p0  <= 1'b0;
      push_word_p0 <= '0;
      length       <= '0;
      overflow     <= 1'b0;
      complete     <= 1'b0;
    end else begin
      push_vld_p0 <= 1'b0;
      complete    <= 1'b0;
      if (drop) overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          odd_p0 <= 1'b0;
          if (bus.rx_req_in) state <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          if (!bus.rx_req_in) begin
            state <= ST_IDLE;
          end else if (bus.mac_rx_valid_in && bus.mac_rx_sof_in) begin
            length   <= 11'd1;
            overflow <= 1'b0;
            if (bus.mac_rx_eof_in) begin
              push_vld_p0  <= 1'b1;
              push_word_p0 <= {bus.mac_rx_data_in, 8'h00};
              odd_p0       <= 1'b0;
              state        <= ST_DRAIN;
            end else begin
              hi_byte_p0 <= bus.mac_rx_data_in;
              odd_p0     <= 1'b1;
              state      <= ST_RECEIVE;
            end
          end
        end
        ST_RECEIVE: begin
          if (!bus.rx_req_in) begin
            odd_p0 <= 1'b0;
            state  <= ST_IDLE;
          end else if (bus.mac_rx_valid_in) begin
            length <= len_nxt;
            if (len_nxt > MAX_LEN) overflow <= 1'b1;
            if (odd_p0) begin
              push_vld_p0  <= 1'b1;
              push_word_p0 <= {hi_byte_p0, bus.mac_rx_data_in};
              odd_p0       <= 1'b0;
            end else if (bus.mac_rx_eof_in) begin
              push_vld_p0  <= 1'b1;
              push_word_p0 <= {bus.mac_rx_data_in, 8'h00};
            end else begin
              hi_byte_p0 <= bus.mac_rx_data_in;
              odd_p0     <= 1'b1;
            end
            if (bus.mac_rx_eof_in) begin
              odd_p0 <= 1'b0;
              state  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.rx_req_in) begin
            state <= ST_IDLE;
          end else if (fifo_empty && !push_vld_p0) begin
            complete <= 1'b1;
            state    <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: popped word appears the cycle after the pop, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1  <= pop;
      data_p1 <= pop ? fifo_rdata : '0;
    end
  end

  assign bus.rx_packet_data_out     = data_p1;
  assign bus.rx_packet_data_rdy_out = vld_p1;
  assign bus.rx_packet_complete_out = complete;
  assign bus.rx_packet_length_out   = length;
  assign bus.rx_overflow_out        = overflow;

endmodule

// File: tb/tb_rx_packet_packer.sv
// Directed bench for rx_packet_packer: table of short frames plus
// hand-written sequences for latency, overflow, abort and reset cases.
module tb_rx_packet_packer;
  import rx_pkt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_packet_packer_if bus();

  rx_packet_packer #(.FIFO_DEPTH(8), .MAX_LEN(11'd1518)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_complete = 0;
  int first_rdy_cyc = 0;
  logic [15:0] words[$];

  typedef struct {
    int          n;
    logic [7:0]  b[4];
    int          nw;
    logic [15:0] w[2];
    int          len;
  } vec_t;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Output monitor: collect words, count completions, check strobe rules.
  always @(negedge clk) begin
    if (bus.rx_packet_data_rdy_out) begin
      if (words.size() == 0) first_rdy_cyc = cyc;
      words.push_back(bus.rx_packet_data_out);
    end
    if (bus.rx_packet_complete_out) n_complete++;
    chk("data_zero_when_idle",
        (!bus.rx_packet_data_rdy_out && bus.rx_packet_data_out != 16'h0) ? 32'd1 : 32'd0, 32'd0);
    chk("complete_with_rdy",
        (bus.rx_packet_data_rdy_out && bus.rx_packet_complete_out) ? 32'd1 : 32'd0, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    bus.mac_rx_data_in  = d;
    bus.mac_rx_valid_in = 1'b1;
    bus.mac_rx_sof_in   = s;
    bus.mac_rx_eof_in   = e;
    tick();
    bus.mac_rx_data_in  = 8'h00;
    bus.mac_rx_valid_in = 1'b0;
    bus.mac_rx_sof_in   = 1'b0;
    bus.mac_rx_eof_in   = 1'b0;
  endtask

  task automatic wait_complete(input int limit, input string nm);
    int k;
    int c0;
    k  = 0;
    c0 = n_complete;
    while (n_complete == c0 && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(nm, n_complete - c0, 1);
  endtask

  task automatic start_req();
    words.delete();
    bus.rx_req_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input int nw,
                         input logic [15:0] w0, input logic [15:0] w1, input int len);
    vecs[i].n = n;
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2; vecs[i].b[3] = b3;
    vecs[i].nw = nw;
    vecs[i].w[0] = w0; vecs[i].w[1] = w1;
    vecs[i].len = len;
  endtask

  initial begin
    int lens[3];
    logic [15:0] last_w;

    set_vec(0, 4, 8'h11, 8'h22, 8'h33, 8'h44, 2, 16'h1122, 16'h3344, 4);
    set_vec(1, 3, 8'hAA, 8'hBB, 8'hCC, 8'h00, 2, 16'hAABB, 16'hCC00, 3);
    set_vec(2, 1, 8'h7E, 8'h00, 8'h00, 8'h00, 1, 16'h7E00, 16'h0000, 1);
    set_vec(3, 2, 8'h5A, 8'hA5, 8'h00, 8'h00, 1, 16'h5AA5, 16'h0000, 2);
    set_vec(4, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 2, 16'hDEAD, 16'hBEEF, 4);

    bus.mac_rx_data_in  = 8'h00;
    bus.mac_rx_valid_in = 1'b0;
    bus.mac_rx_sof_in   = 1'b0;
    bus.mac_rx_eof_in   = 1'b0;
    bus.rx_req_in       = 1'b0;
    bus.test_pop_block  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", bus.rx_packet_data_out, 0);
    chk("rst_rdy", bus.rx_packet_data_rdy_out, 0);
    chk("rst_complete", bus.rx_packet_complete_out, 0);
    chk("rst_length", bus.rx_packet_length_out, 0);
    chk("rst_overflow", bus.rx_overflow_out, 0);
    rst_n = 1'b1;
    tick();

    // Table of short frames
    for (int i = 0; i < 5; i++) begin
      start_req();
      n_complete = 0;
      for (int j = 0; j < vecs[i].n; j++)
        send_byte(vecs[i].b[j], j == 0, j == vecs[i].n - 1);
      wait_complete(40, "tab_complete");
      bus.rx_req_in = 1'b0;
      chk("tab_nwords", words.size(), vecs[i].nw);
      for (int j = 0; j < vecs[i].nw; j++)
        if (j < words.size()) chk("tab_word", words[j], vecs[i].w[j]);
      chk("tab_length", bus.rx_packet_length_out, vecs[i].len);
      chk("tab_overflow", bus.rx_overflow_out, 0);
      tick();
      tick();
    end

    // Frame while req low is ignored; next frame with req high, plus latency
    words.delete();
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1);
    repeat (5) tick();
    chk("noreq_words", words.size(), 0);
    start_req();
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b1);
    begin
      int edge_n;
      edge_n = cyc;
      wait_complete(40, "noreq_complete");
      chk("latency", first_rdy_cyc - edge_n, 2);
    end
    bus.rx_req_in = 1'b0;
    chk("noreq_nwords", words.size(), 1);
    if (words.size() > 0) chk("noreq_word", words[0], 16'h5AA5);
    chk("noreq_length", bus.rx_packet_length_out, 2);
    tick();

    // Push and pop together while full: nothing lost
    start_req();
    bus.test_pop_block = 1'b1;
    for (int j = 0; j < 20; j++) begin
      send_byte(8'(j), j == 0, j == 19);
      if (j == 17) bus.test_pop_block = 1'b0;
    end
    wait_complete(60, "full_pp_complete");
    bus.rx_req_in = 1'b0;
    chk("full_pp_nwords", words.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < words.size()) chk("full_pp_word", words[k], {8'(2 * k), 8'(2 * k + 1)});
    chk("full_pp_overflow", bus.rx_overflow_out, 0);
    chk("full_pp_length", bus.rx_packet_length_out, 20);
    tick();

    // Consumer starved: FIFO overflows, complete still issued
    start_req();
    bus.test_pop_block = 1'b1;
    for (int j = 0; j < 20; j++) send_byte(8'(j), j == 0, j == 19);
    repeat (3) tick();
    chk("starve_overflow_early", bus.rx_overflow_out, 1);
    bus.test_pop_block = 1'b0;
    wait_complete(60, "starve_complete");
    bus.rx_req_in = 1'b0;
    chk("starve_nwords", words.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < words.size()) chk("starve_word", words[k], {8'(2 * k), 8'(2 * k + 1)});
    chk("starve_overflow", bus.rx_overflow_out, 1);
    chk("starve_length", bus.rx_packet_length_out, 20);
    tick();

    // Length boundaries: at MAX_LEN, just past it, and saturation
    lens[0] = 1518;
    lens[1] = 1519;
    lens[2] = 2050;
    for (int i = 0; i < 3; i++) begin
      start_req();
      for (int j = 0; j < lens[i]; j++) send_byte(8'(j), j == 0, j == lens[i] - 1);
      wait_complete(40, "maxlen_complete");
      bus.rx_req_in = 1'b0;
      if (lens[i] % 2 == 1) last_w = {8'(lens[i] - 1), 8'h00};
      else                  last_w = {8'(lens[i] - 2), 8'(lens[i] - 1)};
      chk("maxlen_nwords", words.size(), (lens[i] + 1) / 2);
      if (words.size() > 0) chk("maxlen_last_word", words[words.size() - 1], last_w);
      chk("maxlen_length", bus.rx_packet_length_out, (lens[i] > 2047) ? 2047 : lens[i]);
      chk("maxlen_overflow", bus.rx_overflow_out, (lens[i] > 1518) ? 1 : 0);
      tick();
    end

    // Request dropped after 6 of 10 bytes: no completion, then clean frame
    start_req();
    n_complete = 0;
    for (int j = 0; j < 6; j++) send_byte(8'h10 + 8'(j), j == 0, 1'b0);
    bus.rx_req_in = 1'b0;
    for (int j = 6; j < 10; j++) send_byte(8'h10 + 8'(j), 1'b0, j == 9);
    repeat (8) tick();
    chk("abort_no_complete", n_complete, 0);
    start_req();
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b1);
    wait_complete(40, "abort_next_complete");
    bus.rx_req_in = 1'b0;
    chk("abort_next_nwords", words.size(), 1);
    if (words.size() > 0) chk("abort_next_word", words[0], 16'h0102);
    chk("abort_next_length", bus.rx_packet_length_out, 2);
    tick();

    // Reset mid-frame: outputs clear at once, next frame normal
    start_req();
    send_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", bus.rx_packet_data_out, 0);
    chk("midrst_rdy", bus.rx_packet_data_rdy_out, 0);
    chk("midrst_complete", bus.rx_packet_complete_out, 0);
    chk("midrst_length", bus.rx_packet_length_out, 0);
    chk("midrst_overflow", bus.rx_overflow_out, 0);
    words.delete();
    tick();
    tick();
    rst_n = 1'b1;
    send_byte(8'hB1, 1'b0, 1'b0);
    send_byte(8'hB2, 1'b0, 1'b1);
    repeat (4) tick();
    chk("postrst_nosof_words", words.size(), 0);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b1);
    wait_complete(40, "postrst_complete");
    bus.rx_req_in = 1'b0;
    chk("postrst_nwords", words.size(), 1);
    if (words.size() > 0) chk("postrst_word", words[0], 16'hC33C);
    chk("postrst_length", bus.rx_packet_length_out, 2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
